// File: rtl/spu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : spu_pkg                                                        |
// | Shared widths, types and helpers for the SPU issue-stage scoreboard.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package spu_pkg;

  localparam int NUM_REGS   = 128;
  localparam int REG_ADDR_W = 7;
  localparam int LAT_W      = 3;
  localparam int CNT_W      = 32;
  localparam int NUM_SRC    = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [LAT_W-1:0]      lat_t;

  typedef struct packed {
    reg_addr_t [NUM_SRC-1:0] addr;
    logic      [NUM_SRC-1:0] used;
  } src_vec_t;

  // A zero latency is issued as a one-cycle producer.
  function automatic lat_t eff_lat(input lat_t lat);
    return (lat == '0) ? lat_t'(1) : lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_reg_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sb_reg_counter                                                 |
// | Per-register pending-write countdown; busy while the count is nonzero.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sb_reg_counter
  import spu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  lat_t load_val_i,
  output logic busy_o,
  output lat_t cnt_o
);

  lat_t cnt_q;
  lat_t cnt_d;

  // A fresh load overrides any countdown already in progress.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/spu_issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : spu_issue_scoreboard                                           |
// | Dual-issue RAW/WAW scoreboard gating the even/odd pair into RF/FWD.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spu_issue_scoreboard
  import spu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_even,
  input  logic [3*REG_ADDR_W-1:0] src_addr_even,
  input  logic [NUM_SRC-1:0]      src_use_even,
  input  logic                    wr_even,
  input  logic [REG_ADDR_W-1:0]   rt_even,
  input  logic [LAT_W-1:0]        lat_even,
  input  logic                    valid_odd,
  input  logic [3*REG_ADDR_W-1:0] src_addr_odd,
  input  logic [NUM_SRC-1:0]      src_use_odd,
  input  logic                    wr_odd,
  input  logic [REG_ADDR_W-1:0]   rt_odd,
  input  logic [LAT_W-1:0]        lat_odd,
  output logic                    issue_even,
  output logic                    issue_odd,
  output logic [CNT_W-1:0]        stall_cycles
);

  lat_t              w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;

  lat_t w_lat_even;
  lat_t w_lat_odd;
  lat_t w_init_even;
  lat_t w_init_odd;

  logic w_raw_even;
  logic w_raw_odd;
  logic w_intra_src;
  logic w_waw_even;
  logic w_waw_odd;
  logic w_intra_raw;
  logic w_intra_waw;
  logic w_in_order;
  logic w_stall_evt;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  assign w_lat_even  = eff_lat(lat_even);
  assign w_lat_odd   = eff_lat(lat_odd);
  assign w_init_even = w_lat_even - 1'b1;
  assign w_init_odd  = w_lat_odd - 1'b1;

  // Same-cycle writes to one rt from both pipes are excluded by the intra-pair WAW check.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic w_ld_even;
    logic w_ld_odd;

    assign w_ld_even = issue_even & wr_even & (rt_even == reg_addr_t'(r));
    assign w_ld_odd  = issue_odd & wr_odd & (rt_odd == reg_addr_t'(r));

    sb_reg_counter u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (w_ld_even | w_ld_odd),
      .load_val_i (w_ld_even ? w_init_even : w_init_odd),
      .busy_o     (w_busy[r]),
      .cnt_o      (w_cnt[r])
    );
  end

  always_comb begin
    w_raw_even  = 1'b0;
    w_raw_odd   = 1'b0;
    w_intra_src = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_use_even[i] && w_busy[src_addr_even[i*REG_ADDR_W +: REG_ADDR_W]]) begin
        w_raw_even = 1'b1;
      end
      if (src_use_odd[i] && w_busy[src_addr_odd[i*REG_ADDR_W +: REG_ADDR_W]]) begin
        w_raw_odd = 1'b1;
      end
      if (src_use_odd[i] && (src_addr_odd[i*REG_ADDR_W +: REG_ADDR_W] == rt_even)) begin
        w_intra_src = 1'b1;
      end
    end
  end

  // A writer may overtake a pending one only if it lands strictly later.
  assign w_waw_even  = wr_even & (w_cnt[rt_even] >= w_lat_even);
  assign w_waw_odd   = wr_odd & (w_cnt[rt_odd] >= w_lat_odd);
  assign w_intra_raw = valid_even & wr_even & w_intra_src;
  assign w_intra_waw = wr_even & wr_odd & (rt_even == rt_odd);
  assign w_in_order  = valid_even & ~issue_even;

  assign issue_even = valid_even & ~w_raw_even & ~w_waw_even & ~reset;
  assign issue_odd  = valid_odd & ~w_raw_odd & ~w_waw_odd & ~w_intra_raw
                    & ~w_intra_waw & ~w_in_order & ~reset;

  assign w_stall_evt = (valid_even & ~issue_even) | (valid_odd & ~issue_odd);

  always_comb begin
    stall_d = stall_q;
    if (w_stall_evt && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_spu_issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_spu_issue_scoreboard                                        |
// | Directed vector table plus random pairs against a time-stamp model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spu_issue_scoreboard;

  typedef struct {
    logic        v;
    logic [20:0] src;
    logic [2:0]  um;
    logic        w;
    logic [6:0]  rt;
    logic [2:0]  lat;
  } ins_t;

  typedef struct {
    logic rst;
    ins_t e;
    ins_t o;
    logic xe;
    logic xo;
    int   xs;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_even, wr_even, valid_odd, wr_odd;
  logic [20:0] src_addr_even, src_addr_odd;
  logic [2:0]  src_use_even, src_use_odd, lat_even, lat_odd;
  logic [6:0]  rt_even, rt_odd;
  logic        issue_even, issue_odd;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spu_issue_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .valid_even    (valid_even),
    .src_addr_even (src_addr_even),
    .src_use_even  (src_use_even),
    .wr_even       (wr_even),
    .rt_even       (rt_even),
    .lat_even      (lat_even),
    .valid_odd     (valid_odd),
    .src_addr_odd  (src_addr_odd),
    .src_use_odd   (src_use_odd),
    .wr_odd        (wr_odd),
    .rt_odd        (rt_odd),
    .lat_odd       (lat_odd),
    .issue_even    (issue_even),
    .issue_odd     (issue_odd),
    .stall_cycles  (stall_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input ins_t e, input ins_t o);
    reset         = r;
    valid_even    = e.v;
    src_addr_even = e.src;
    src_use_even  = e.um;
    wr_even       = e.w;
    rt_even       = e.rt;
    lat_even      = e.lat;
    valid_odd     = o.v;
    src_addr_odd  = o.src;
    src_use_odd   = o.um;
    wr_odd        = o.w;
    rt_odd        = o.rt;
    lat_odd       = o.lat;
  endtask

  function automatic ins_t ins(input logic v, input logic [6:0] a, input logic [2:0] u,
                               input logic w, input logic [6:0] rt, input logic [2:0] lat);
    ins_t x;
    x.v = v; x.src = {a, a, a}; x.um = u; x.w = w; x.rt = rt; x.lat = lat;
    return x;
  endfunction

  function automatic vec_t row(input logic r, input ins_t e, input ins_t o,
                               input logic xe, input logic xo, input int xs);
    vec_t t;
    t.rst = r; t.e = e; t.o = o; t.xe = xe; t.xo = xo; t.xs = xs;
    return t;
  endfunction

  // Reference model: each register remembers the absolute cycle its value becomes readable.
  int          ready_at [128];
  int          now = 0;
  logic [31:0] stall_m = 0;

  function automatic int rem(input logic [6:0] r);
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic int eff(input logic [2:0] l);
    return (l == 3'd0) ? 1 : int'(l);
  endfunction

  function automatic logic raw_hz(input ins_t x);
    for (int i = 0; i < 3; i++)
      if (x.um[i] && rem(x.src[i*7 +: 7]) > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic reads(input ins_t x, input logic [6:0] r);
    for (int i = 0; i < 3; i++)
      if (x.um[i] && x.src[i*7 +: 7] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic r, input ins_t e, input ins_t o,
                            output logic xe, output logic xo);
    xe = !r && e.v && !raw_hz(e) && !(e.w && rem(e.rt) >= eff(e.lat));
    xo = !r && o.v && !raw_hz(o) && !(o.w && rem(o.rt) >= eff(o.lat))
         && !(e.v && e.w && reads(o, e.rt)) && !(e.w && o.w && e.rt == o.rt)
         && !(e.v && !xe);
    if (r) begin
      for (int k = 0; k < 128; k++) ready_at[k] = 0;
      stall_m = 0;
    end else begin
      if (xe && e.w) ready_at[e.rt] = now + eff(e.lat);
      if (xo && o.w) ready_at[o.rt] = now + eff(o.lat);
      if (((e.v && !xe) || (o.v && !xo)) && stall_m != 32'hFFFF_FFFF) stall_m++;
    end
    now++;
  endtask

  function automatic ins_t rnd_ins();
    ins_t x;
    x.v   = ($urandom_range(3) != 0);
    x.src = {7'($urandom_range(15)), 7'($urandom_range(15)), 7'($urandom_range(15))};
    x.um  = 3'($urandom_range(7));
    x.w   = 1'($urandom_range(1));
    x.rt  = 7'($urandom_range(15));
    x.lat = 3'($urandom_range(7));
    return x;
  endfunction

  initial begin
    vec_t tbl[$];
    ins_t none, e, o;
    logic xe, xo, r;

    none = ins(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 128; k++) ready_at[k] = 0;
    drive(1'b1, none, none);

    // reset held with a valid even instruction, then an independent pair
    tbl.push_back(row(1, ins(1, 1, 3'b100, 0, 0, 0), none, 0, 0, 0));
    tbl.push_back(row(1, ins(1, 1, 3'b100, 0, 0, 0), none, 0, 0, 0));
    tbl.push_back(row(0, ins(1, 1, 3'b100, 1, 20, 1), ins(1, 2, 3'b100, 1, 21, 1), 1, 1, 0));
    // RAW on r5 with latency 6
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 5, 6), none, 1, 0, 0));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(row(0, ins(1, 5, 3'b100, 0, 0, 0), none, 0, 0, k));
    tbl.push_back(row(0, ins(1, 5, 3'b100, 0, 0, 0), none, 1, 0, 5));
    // latency 1 and 0 producers are bypassed next cycle
    tbl.push_back(row(0, none, ins(1, 0, 3'b000, 1, 9, 1), 0, 1, 5));
    tbl.push_back(row(0, ins(1, 9, 3'b010, 0, 0, 0), none, 1, 0, 5));
    tbl.push_back(row(0, none, ins(1, 0, 3'b000, 1, 9, 0), 0, 1, 5));
    tbl.push_back(row(0, ins(1, 9, 3'b001, 0, 0, 0), none, 1, 0, 5));
    // intra-pair RAW on r3
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 3, 1), ins(1, 3, 3'b001, 0, 0, 0), 1, 0, 6));
    tbl.push_back(row(0, none, ins(1, 3, 3'b001, 0, 0, 0), 0, 1, 6));
    // WAW on r7: pending count 4 vs new latency 2, then overtaking and equal-count cases
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 7, 5), none, 1, 0, 6));
    for (int k = 7; k <= 9; k++)
      tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 7, 2), none, 0, 0, k));
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 7, 2), none, 1, 0, 9));
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 7, 6), none, 1, 0, 9));
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 7, 6), none, 1, 0, 9));
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 7, 5), none, 0, 0, 10));
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 7, 5), none, 1, 0, 10));
    // in-order blocking behind r10, then reset in the middle of a stall
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 10, 3), none, 1, 0, 10));
    tbl.push_back(row(0, ins(1, 10, 3'b100, 0, 0, 0), ins(1, 0, 3'b000, 1, 30, 1), 0, 0, 11));
    tbl.push_back(row(0, ins(1, 10, 3'b100, 0, 0, 0), ins(1, 0, 3'b000, 1, 30, 1), 0, 0, 12));
    tbl.push_back(row(0, ins(1, 10, 3'b100, 0, 0, 0), ins(1, 0, 3'b000, 1, 30, 1), 1, 1, 12));
    tbl.push_back(row(0, ins(1, 0, 3'b000, 1, 10, 7), none, 1, 0, 12));
    tbl.push_back(row(0, ins(1, 10, 3'b100, 0, 0, 0), ins(1, 0, 3'b000, 1, 30, 1), 0, 0, 13));
    tbl.push_back(row(1, ins(1, 10, 3'b100, 0, 0, 0), ins(1, 0, 3'b000, 1, 30, 1), 0, 0, 0));
    tbl.push_back(row(0, ins(1, 10, 3'b100, 0, 0, 0), ins(1, 0, 3'b000, 1, 30, 1), 1, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].e, tbl[i].o);
      @(negedge clk);
      chk($sformatf("row%0d_issue_even", i), {31'd0, issue_even}, {31'd0, tbl[i].xe});
      chk($sformatf("row%0d_issue_odd", i), {31'd0, issue_odd}, {31'd0, tbl[i].xo});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_stall_cycles", i), stall_cycles, 32'(tbl[i].xs));
    end

    // random pairs held stable until the model says they issue
    e = rnd_ins();
    o = rnd_ins();
    for (int k = 0; k < 800; k++) begin
      r = (k == 0) || ($urandom_range(63) == 0);
      drive(r, e, o);
      @(negedge clk);
      model_step(r, e, o, xe, xo);
      chk($sformatf("rnd%0d_issue_even", k), {31'd0, issue_even}, {31'd0, xe});
      chk($sformatf("rnd%0d_issue_odd", k), {31'd0, issue_odd}, {31'd0, xo});
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_stall_cycles", k), stall_cycles, stall_m);
      if (!e.v || xe) e = rnd_ins();
      if (!o.v || xo) o = rnd_ins();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
